br_update_ctrl: RTL
===================

# br_update_ctrl

Branch-predictor update controller placed between the fetch/decode prediction point and the global-history pattern history table (PHT). It keeps the speculative global history register (GHR) used to index the PHT at fetch, and records each predicted branch with its history snapshot in an in-order in-flight queue. When a branch resolves it retires the matching entry, schedules the single PHT write-back, and on a misprediction flushes the queue and restores history.

## Interface
- GHR_W, 3, history width; PHT index width (PHT depth = 2^GHR_W)
- DEPTH, 4, in-flight branch entries; power of two, >= 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Stall_Detected  in  1  pipeline stall; no push/pop accepted while high
- pred_valid  in  1  fetch presents a predicted branch (push request)
- pred_taken  in  1  PHT prediction bit for that branch
- pred_ready  out  1  push accepted this cycle if pred_valid high
- res_valid  in  1  execute resolved the oldest in-flight branch (pop)
- res_taken  in  1  actual branch outcome
- spec_ghr  out  GHR_W  speculative history; PHT read index for fetch
- upd_en  out  1  one-cycle PHT write strobe
- upd_idx  out  GHR_W  PHT entry to update (snapshot taken at prediction)
- upd_taken  out  1  outcome fed to the PHT 2-bit counter
- flush  out  1  one-cycle misprediction flush to front end
- occupancy  out  $clog2(DEPTH)+1  entries in flight
- mispredict_cnt  out  16  saturating misprediction count

## Operation
- Reset: state EMPTY, queue empty, spec_ghr=0, arch GHR=0, pred_ready=1, upd_en=0, upd_idx=0, upd_taken=0, flush=0, occupancy=0, mispredict_cnt=0.
- History shift rule (both GHRs): new = {bit, old[GHR_W-1:1]}, newest outcome in the MSB.
- Push accepted = pred_valid & pred_ready & !Stall_Detected: entry {spec_ghr, pred_taken} written at tail; spec_ghr shifts in pred_taken.
- Pop accepted = res_valid & !Stall_Detected & occupancy!=0: head entry retired; arch GHR shifts in res_taken; upd_idx<=entry.ghr, upd_taken<=res_taken, upd_en<=1 next cycle.
- Mispredict = pop accepted & res_taken != entry.pred_taken: next cycle flush=1, queue cleared (occupancy=0), spec_ghr<=arch GHR after shift, mispredict_cnt+1 (saturates at 0xFFFF).
- res_valid with empty queue: ignored; no update, no flush.
- State machine: EMPTY (occupancy=0) -> BUSY on push; BUSY -> EMPTY when last entry popped without push; BUSY/EMPTY -> RECOVER on mispredict; RECOVER -> EMPTY unconditionally after one cycle.
- pred_ready = (state != RECOVER) & (occupancy != DEPTH); combinationally independent of res_valid and Stall_Detected.
- Simultaneous push and correct pop: both take effect; occupancy unchanged.
- Simultaneous push and mispredicting pop: push discarded (wrong path); spec_ghr restore wins.
- Full queue: push ignored even if a pop happens the same cycle.
- Pointers wrap modulo DEPTH; separate occupancy counter distinguishes full/empty.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight entries lost, no upd_en or flush emitted.

## Timing
- spec_ghr, occupancy: updated at the edge accepting the push/pop; visible next cycle.
- upd_en/upd_idx/upd_taken: registered, valid exactly one cycle after pop; upd_en never high two cycles for one pop.
- flush: high exactly one cycle, coincident with RECOVER; pred_ready=0 that cycle.
- Pulses depend only on previous-cycle acceptance; Stall_Detected in the pulse cycle does not suppress them.
- Throughput: one push and one pop per cycle; PHT sees at most one update per cycle.

## Structure
- Shared package br_pred_pkg: state enum {EMPTY, BUSY, RECOVER}; entry struct {ghr[GHR_W-1:0], pred_taken}; default GHR_W.
- Sub-module br_hist_fifo: DEPTH-entry circular buffer (push/pop/clear, occupancy). Controller FSM, GHRs, update/flush registers and counter live in br_update_ctrl.

## Test plan
- Reset then idle -> spec_ghr=0, pred_ready=1, occupancy=0, upd_en=0, flush=0.
- Push taken, taken, not-taken (GHR_W=3) -> spec_ghr 000->100->110->011; occupancy=3; stored snapshots 000,100,110.
- Pop first with res_taken=1 -> next cycle upd_en=1, upd_idx=000, upd_taken=1, flush=0; occupancy=2.
- Pop second with res_taken=0 while pushing -> flush=1 one cycle, upd_idx=100, upd_taken=0, occupancy=0, spec_ghr=010, mispredict_cnt=1, push discarded, pred_ready=0 in RECOVER.
- Push 4 with DEPTH=4 -> pred_ready=0; fifth push plus concurrent correct pop -> fifth push dropped, occupancy=3.
- Stall_Detected=1 with pred_valid and res_valid high -> no state change; res_valid on empty queue -> no upd_en, no flush.

Source files
------------

// File: rtl/br_pred_pkg.sv
// Shared types for the branch-predictor update path: controller states and the
// in-flight entry layout (history snapshot plus the prediction made with it).
package br_pred_pkg;

  localparam int GHR_W_DEF = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } br_state_t;

  typedef struct packed {
    logic [GHR_W_DEF-1:0] ghr;
    logic                 pred_taken;
  } br_entry_t;

endpackage

// File: rtl/br_hist_fifo.sv
// In-order circular buffer of in-flight branches; clear wins over push/pop,
// and an occupancy counter disambiguates full from empty.
module br_hist_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] occupancy
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] occ_reg;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok   = push && (occ_reg != CW'(DEPTH)) && !clear;
  assign pop_ok    = pop && (occ_reg != '0) && !clear;
  assign rdata     = mem[rd_ptr_reg];
  assign occupancy = occ_reg;

  // Payload needs no reset: occupancy gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/br_update_ctrl.sv
// Speculative/architectural global history, in-flight branch tracking, PHT
// write-back scheduling and misprediction recovery.
module br_update_ctrl
  import br_pred_pkg::*;
#(
  parameter int GHR_W = GHR_W_DEF,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall_Detected,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic [GHR_W-1:0] spec_ghr,
  output logic             upd_en,
  output logic [GHR_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             flush,
  output logic [CW-1:0]    occupancy,
  output logic [15:0]      mispredict_cnt
);

  br_state_t        state_reg, state_next;
  logic [GHR_W-1:0] spec_ghr_reg;
  logic [GHR_W-1:0] arch_ghr_reg;
  logic [GHR_W-1:0] arch_ghr_next;
  logic             upd_en_reg;
  logic [GHR_W-1:0] upd_idx_reg;
  logic             upd_taken_reg;
  logic [15:0]      mis_cnt_reg;
  logic [GHR_W:0]   head_entry;
  logic             push_acc;
  logic             pop_acc;
  logic             mispred;

  assign push_acc = pred_valid && pred_ready && !Stall_Detected;
  assign pop_acc  = res_valid && !Stall_Detected && (occupancy != '0);
  assign mispred  = pop_acc && (res_taken != head_entry[0]);

  assign arch_ghr_next = pop_acc ? {res_taken, arch_ghr_reg[GHR_W-1:1]} : arch_ghr_reg;

  // A mispredicting pop kills any same-cycle push and empties the queue.
  br_hist_fifo #(
    .W    (GHR_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_acc && !mispred),
    .pop      (pop_acc),
    .clear    (mispred),
    .wdata    ({spec_ghr_reg, pred_taken}),
    .rdata    (head_entry),
    .occupancy(occupancy)
  );

  always_comb begin
    state_next = state_reg;
    pred_ready = (occupancy != CW'(DEPTH));
    flush      = 1'b0;
    case (state_reg)
      RECOVER: begin
        state_next = EMPTY;
        pred_ready = 1'b0;
        flush      = 1'b1;
      end
      default: begin
        if (mispred)                                 state_next = RECOVER;
        else if (push_acc)                           state_next = BUSY;
        else if (pop_acc && (occupancy == CW'(1)))   state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      spec_ghr_reg  <= '0;
      arch_ghr_reg  <= '0;
      upd_en_reg    <= 1'b0;
      upd_idx_reg   <= '0;
      upd_taken_reg <= 1'b0;
      mis_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      arch_ghr_reg <= arch_ghr_next;
      upd_en_reg   <= pop_acc;
      if (pop_acc) begin
        upd_idx_reg   <= head_entry[GHR_W:1];
        upd_taken_reg <= res_taken;
      end
      if (mispred) begin
        spec_ghr_reg <= arch_ghr_next;
        if (mis_cnt_reg != 16'hFFFF) mis_cnt_reg <= mis_cnt_reg + 16'd1;
      end else if (push_acc) begin
        spec_ghr_reg <= {pred_taken, spec_ghr_reg[GHR_W-1:1]};
      end
    end
  end

  assign spec_ghr       = spec_ghr_reg;
  assign upd_en         = upd_en_reg;
  assign upd_idx        = upd_idx_reg;
  assign upd_taken      = upd_taken_reg;
  assign mispredict_cnt = mis_cnt_reg;

endmodule
